// File: rtl/aes_pkg.sv
// Shared AES tables and GF(2^8) helpers for the encrypt and decrypt datapaths.
package aes_pkg;

  localparam int          NUM_ROUNDS = 10;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  typedef enum logic {IDLE, RUN} fsm_e;

  // Forward S-box, written in FIPS-197 order (entry 0x00 first, leftmost).
  // The leftmost entry lands at index 255, so a lookup indexes with ~x.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant for rounds 1..10; anything else is unused and maps to 0.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, rot, sub, tmp, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;

  // RotWord then SubWord on the last word, with the round constant in byte 0.
  assign rot = {w3[23:0], w3[31:24]};
  assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign tmp = sub ^ {rcon, 24'h000000};

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, ten rounds per block.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         valid_out,
  output logic [127:0] data_out
);

  fsm_e         fsm;
  logic [127:0] state_q, key_q;
  logic [3:0]   round_q;

  logic [127:0] sb, sr, mc, next_key, rnd_out;

  // Column mix of four bytes; 3x is computed as 2x ^ x.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  aes_key_step u_key_step (
    .key      (key_q),
    .rcon     (rcon_of(round_q)),
    .next_key (next_key)
  );

  // Byte b occupies bits [127-8b -: 8]; byte 4c+r is row r of column c.
  for (genvar b = 0; b < 16; b++) begin : g_sub
    assign sb[127-8*b -: 8] = sbox(state_q[127-8*b -: 8]);
  end

  // Row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  // The last round skips MixColumns.
  assign rnd_out = ((round_q == LAST_ROUND) ? sr : mc) ^ next_key;

  // Control FSM and datapath registers; reset and aborts clear everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      round_q   <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state_q <= data_in ^ key_in;
            key_q   <= key_in;
            round_q <= 4'd1;
            busy    <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          state_q <= rnd_out;
          key_q   <= next_key;
          if (round_q == LAST_ROUND) begin
            data_out  <= rnd_out;
            valid_out <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Scoreboard bench for the iterative AES-128 encryptor using FIPS-197 vectors.
module tb_aes_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         busy, valid_out;
  logic [127:0] data_out;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] ct;
    int           cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   vcount = 0;

  aes_encrypt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .key_in    (key_in),
    .busy      (busy),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge: assert start with a vector; an accepted start
  // shows its result 11 negedges later.
  task automatic drive(input logic [127:0] k, input logic [127:0] pt,
                       input logic [127:0] ct, input bit accept);
    exp_t e;
    start   = 1'b1;
    key_in  = k;
    data_in = pt;
    if (accept) begin
      e.ct  = ct;
      e.cyc = cyc + 11;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every valid_out pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      exp_t e;
      vcount++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 128'd1, 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("ciphertext", data_out, e.ct);
        check("latency", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    int busy_err;
    int v0;

    repeat (3) @(negedge clk);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_valid", 128'(valid_out), 128'd0);
    check("reset_data_out", data_out, 128'd0);
    rst = 1'b0;

    // Single blocks: C.1 then Appendix B.
    @(negedge clk);
    drive(C1_KEY, C1_PT, C1_CT, 1'b1);
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);
    drive(B_KEY, B_PT, B_CT, 1'b1);
    @(negedge clk) start = 1'b0;
    repeat (14) @(negedge clk);

    // Back-to-back: second start lands in the first valid cycle.
    drive(C1_KEY, C1_PT, C1_CT, 1'b1);
    busy_err = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== ((i == 11 || i == 22) ? 1'b0 : 1'b1)) busy_err++;
      if (i == 11) drive(B_KEY, B_PT, B_CT, 1'b1);
    end
    start = 1'b0;
    check("b2b_busy_pattern", 128'(busy_err), 128'd0);
    repeat (3) @(negedge clk);

    // Start held and inputs churned during RUN must not disturb the block.
    v0 = vcount;
    drive(C1_KEY, C1_PT, C1_CT, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
    end
    @(negedge clk) start = 1'b0;
    repeat (12) @(negedge clk);
    check("held_start_one_pulse", 128'(vcount - v0), 128'd1);

    // Abort mid-run: nothing is pushed, so any valid_out is flagged.
    drive(C1_KEY, C1_PT, C1_CT, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_data_out", data_out, 128'd0);
    check("abort_valid", 128'(valid_out), 128'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Fresh block after the abort.
    drive(C1_KEY, C1_PT, C1_CT, 1'b1);
    @(negedge clk) start = 1'b0;
    repeat (15) @(negedge clk);

    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
